// File: rtl/clk_reset_seq.sv
// Multi-channel phase-clock / chip-reset sequencer with run/halt, run-length limit
// and an optional single-step handshake compiled in with CLKSEQ_STEP_EN.
module clk_reset_seq #(
  parameter int NCHAN        = 2,
  parameter int HALF_W       = 8,
  parameter int RESET_CYCLES = 8,
  parameter int RUN_W        = 32
) (
  input  logic                    eclk,
  input  logic                    ereset,
  input  logic [NCHAN*HALF_W-1:0] half_period,
  input  logic                    run,
  input  logic [RUN_W-1:0]        run_limit,
  input  logic [NCHAN-1:0]        rst_req,
  input  logic                    step_req,
  output logic                    step_ack,
  output logic [NCHAN-1:0]        clk0,
  output logic [NCHAN-1:0]        res,
  output logic [RUN_W-1:0]        cycles,
  output logic                    done
);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef CLKSEQ_STEP_EN
  localparam logic [1:0] ST_STEP = 2'd2;
`endif
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             active;
  logic [NCHAN-1:0] tog;
  logic [NCHAN-1:0] fall;
  logic [RUN_W-1:0] cycles_next;
  logic             limit_hit;

  assign active = (state == ST_RUN)
`ifdef CLKSEQ_STEP_EN
                || (state == ST_STEP)
`endif
                ;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic [HALF_W-1:0] cnt;
      logic [HALF_W-1:0] hp;
      logic [HALF_W-1:0] hp_field;
      logic [HALF_W-1:0] hp_eff;
      logic              phase;
      logic              res_bit;
      logic [RC_W-1:0]   rcnt;
      logic [RC_W-1:0]   rcnt_next;

      assign hp_field = half_period[gi*HALF_W +: HALF_W];
      assign hp_eff   = (hp_field == '0) ? HALF_W'(1) : hp_field;
      assign tog[gi]  = active && (cnt == hp - HALF_W'(1));
      assign fall[gi] = tog[gi] && phase;
      assign clk0[gi] = phase;
      assign res[gi]  = res_bit;

      // A reload request beats a coincident falling-edge decrement.
      always_comb begin
        rcnt_next = rcnt;
        if (rst_req[gi])
          rcnt_next = RC_W'(RESET_CYCLES);
        else if (fall[gi] && (rcnt != '0))
          rcnt_next = rcnt - RC_W'(1);
      end

      always_ff @(posedge eclk) begin
        if (!ereset) begin
          cnt     <= '0;
          hp      <= hp_eff;
          phase   <= 1'b0;
          rcnt    <= RC_W'(RESET_CYCLES);
          res_bit <= 1'b0;
        end else begin
          if (tog[gi]) begin
            cnt   <= '0;
            hp    <= hp_eff;
            phase <= ~phase;
          end else if (active) begin
            cnt <= cnt + HALF_W'(1);
          end
          rcnt    <= rcnt_next;
          res_bit <= (rcnt_next == '0);
        end
      end
    end
  endgenerate

  assign cycles_next = (fall[0] && (cycles != '1)) ? cycles + RUN_W'(1) : cycles;
  assign limit_hit   = (run_limit != '0) && (cycles_next == run_limit);

  always_comb begin
    state_next = state;
    case (state)
      ST_HALT: begin
        if (run)
          state_next = ST_RUN;
`ifdef CLKSEQ_STEP_EN
        else if (step_req)
          state_next = ST_STEP;
`endif
      end
      ST_RUN: if (!run) state_next = ST_HALT;
`ifdef CLKSEQ_STEP_EN
      ST_STEP: if (tog[0]) state_next = run ? ST_RUN : ST_HALT;
`endif
      default: state_next = state;
    endcase
    if (limit_hit)
      state_next = ST_DONE;
  end

  always_ff @(posedge eclk) begin
    if (!ereset) begin
      state  <= ST_HALT;
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cycles <= cycles_next;
      done   <= (state_next == ST_DONE);
    end
  end

`ifdef CLKSEQ_STEP_EN
  // Ack lags the channel-0 toggle by one eclk; a step that hits the limit gets none.
  logic step_pend;
  always_ff @(posedge eclk) begin
    if (!ereset) begin
      step_pend <= 1'b0;
      step_ack  <= 1'b0;
    end else begin
      step_pend <= (state == ST_STEP) && tog[0] && !limit_hit;
      step_ack  <= step_pend;
    end
  end
`else
  logic unused_step;
  assign unused_step = step_req;
  assign step_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq: expected events are queued up front and
// popped as the DUT produces them.
module tb_clk_reset_seq;
  localparam int NCHAN = 2;
  localparam int HALF_W = 8;
  localparam int RESET_CYCLES = 8;
  localparam int RUN_W = 32;

  logic                    eclk = 1'b0;
  logic                    ereset = 1'b0;
  logic [NCHAN*HALF_W-1:0] half_period = '0;
  logic                    run = 1'b0;
  logic [RUN_W-1:0]        run_limit = '0;
  logic [NCHAN-1:0]        rst_req = '0;
  logic                    step_req = 1'b0;
  logic                    step_ack;
  logic [NCHAN-1:0]        clk0;
  logic [NCHAN-1:0]        res;
  logic [RUN_W-1:0]        cycles;
  logic                    done;

  clk_reset_seq #(
    .NCHAN(NCHAN), .HALF_W(HALF_W), .RESET_CYCLES(RESET_CYCLES), .RUN_W(RUN_W)
  ) dut (
    .eclk(eclk), .ereset(ereset), .half_period(half_period), .run(run),
    .run_limit(run_limit), .rst_req(rst_req), .step_req(step_req),
    .step_ack(step_ack), .clk0(clk0), .res(res), .cycles(cycles), .done(done)
  );

  always #5 eclk = ~eclk;

  typedef struct { int cyc; string tag; } ev_t;
  ev_t exp_q[$];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  logic       prev_c0;
  logic [1:0] prev_res;
  logic       prev_done;
  // watch bits: 0 c0_tog, 1 res0_rise, 2 res1_rise, 3 res1_fall, 4 done_rise, 5 ack
  logic [5:0] watch = '0;

  task automatic push(input int c, input string tag);
    ev_t e;
    e.cyc = c;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input string tag);
    ev_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      e.cyc = -1;
      e.tag = "none";
    end else begin
      e = exp_q.pop_front();
    end
    $display("event %s at cycle %0d (expected %s at %0d)", tag, cyc, e.tag, e.cyc);
    assert (e.cyc === cyc && e.tag == tag) else begin
      n_fail++;
      $error("FAIL ev_%s: observed at cycle %0d, expected %s at cycle %0d", tag, cyc, e.tag, e.cyc);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    $display("check %s: observed %0d expected %0d", tag, obs, expv);
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge eclk);
    #1;
    cyc++;
    if (watch[0] && (clk0[0] !== prev_c0)) check_ev("c0_tog");
    if (watch[1] && res[0] === 1'b1 && prev_res[0] === 1'b0) check_ev("res0_rise");
    if (watch[2] && res[1] === 1'b1 && prev_res[1] === 1'b0) check_ev("res1_rise");
    if (watch[3] && res[1] === 1'b0 && prev_res[1] === 1'b1) check_ev("res1_fall");
    if (watch[4] && done === 1'b1 && prev_done === 1'b0) check_ev("done_rise");
    if (watch[5] && step_ack !== 1'b0) check_ev("ack");
    prev_c0   = clk0[0];
    prev_res  = res;
    prev_done = done;
  endtask

  // Reset for two edges (outputs checked after the first), then release.
  task automatic start(input logic [7:0] hp0, input logic [7:0] hp1,
                       input logic [31:0] lim, input logic r, input logic [5:0] w);
    watch       = '0;
    ereset      = 1'b0;
    half_period = {hp1, hp0};
    run_limit   = lim;
    run         = r;
    rst_req     = '0;
    step_req    = 1'b0;
    tick();
    check_val("rst_clk0", 32'(clk0), 0);
    check_val("rst_res", 32'(res), 0);
    check_val("rst_cycles", cycles, 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_step_ack", 32'(step_ack), 0);
    tick();
    ereset = 1'b1;
    cyc    = 0;
    watch  = w;
  endtask

  task automatic end_section(input string tag);
    n_assert++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL %s_pending: observed %0d unmatched events, expected 0", tag, exp_q.size());
    end
    exp_q.delete();
    watch = '0;
  endtask

  initial begin
    // Free run {4,1}: ch0 toggles every 4 active edges, first active edge is cycle 2.
    start(8'd4, 8'd1, 32'd0, 1'b1, 6'b000111);
    for (int c = 1; c <= 70; c++) begin
      if (c >= 5 && ((c - 1) % 4) == 0) push(c, "c0_tog");
      if (c == 65) push(c, "res0_rise");
      if (c == 17) push(c, "res1_rise");
    end
    repeat (70) tick();
    check_val("t1_cycles", cycles, 8);
    end_section("t1");

    // rst_req[1] on a clk0[1] fall (cycle 19) after res[1] has risen.
    start(8'd4, 8'd1, 32'd0, 1'b1, 6'b001110);
    push(17, "res1_rise");
    push(19, "res1_fall");
    push(35, "res1_rise");
    push(65, "res0_rise");
    repeat (18) tick();
    rst_req = 2'b10;
    tick();
    rst_req = 2'b00;
    repeat (51) tick();
    end_section("t3");

    // half_period[0] 2 -> 5 in the middle of the half ending at cycle 5.
    start(8'd2, 8'd1, 32'd0, 1'b1, 6'b000001);
    push(3, "c0_tog");
    push(5, "c0_tog");
    push(10, "c0_tog");
    push(15, "c0_tog");
    push(20, "c0_tog");
    push(25, "c0_tog");
    repeat (4) tick();
    half_period[7:0] = 8'd5;
    repeat (22) tick();
    end_section("t5");

    // Single-step with run=0, hp0=3; extra step_req during STEP is ignored.
    start(8'd3, 8'd1, 32'd0, 1'b0, 6'b100001);
`ifdef CLKSEQ_STEP_EN
    push(6, "c0_tog");
    push(7, "ack");
    push(14, "c0_tog");
    push(15, "ack");
`endif
    repeat (2) tick();
    step_req = 1'b1;
    tick();
    tick();
    step_req = 1'b0;
    repeat (6) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (7) tick();
`ifdef CLKSEQ_STEP_EN
    check_val("t4_clk0", 32'(clk0[0]), 0);
    check_val("t4_cycles", cycles, 1);
`else
    check_val("t4_clk0", 32'(clk0[0]), 0);
    check_val("t4_cycles", cycles, 0);
`endif
    end_section("t4");

    // Run limit 5 with hp0=2: done on the 5th fall at cycle 21, then frozen.
    start(8'd2, 8'd1, 32'd5, 1'b1, 6'b010001);
    for (int k = 1; k <= 10; k++) push(1 + 2 * k, "c0_tog");
    push(21, "done_rise");
    repeat (40) tick();
    check_val("t2_cycles", cycles, 5);
    check_val("t2_done", 32'(done), 1);
    check_val("t2_clk0", 32'(clk0), 0);
    check_val("t2_res", 32'(res), 2);
    end_section("t2");

    // Reset straight out of DONE, then a fresh unlimited run.
    start(8'd2, 8'd1, 32'd0, 1'b1, 6'b010000);
    repeat (12) tick();
    check_val("t6_cycles", cycles, 2);
    check_val("t6_done", 32'(done), 0);
    end_section("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_reset_seq.md
# clk_reset_seq

Parametrised clock-phase and reset sequencer for netlist-simulated chip SoCs. It replaces a fixed-divider clock/reset pair with NCHAN independent phase-clock channels, each with a runtime-programmable half-period and its own chip reset sequence. It adds a global run/halt control, a run-length limit that freezes all clocks on expiry, and an optional single-step handshake. It sits at SoC top level and drives the chip phase inputs (clk0) and active-low chip reset pins (res) of each instantiated chip.

## Interface
- NCHAN, 2, number of phase/reset channels
- HALF_W, 8, width of each half-period field
- RESET_CYCLES, 8, full phase cycles res is held low after reset or rst_req (≥1)
- RUN_W, 32, width of cycle counter and run limit
- eclk  input  1  system clock; all logic on posedge
- ereset  input  1  reset, synchronous, active-low
- half_period  input  NCHAN*HALF_W  per-channel half-period in eclk cycles; channel i at bits [i*HALF_W +: HALF_W]; value 0 treated as 1
- run  input  1  level; 1 = free-run dividers
- run_limit  input  RUN_W  channel-0 cycle count at which to stop; 0 = unlimited
- rst_req  input  NCHAN  per-channel one-cycle pulse restarting that channel's reset sequence
- step_req  input  1  single-step request pulse
- step_ack  output  1  one-cycle pulse, step complete
- clk0  output  NCHAN  phase clocks
- res  output  NCHAN  chip resets, active-low
- cycles  output  RUN_W  completed channel-0 phase cycles
- done  output  1  sticky, run limit reached

## Operation
- Global states: HALT, RUN, STEP, DONE. Dividers count only in RUN or STEP.
- HALT→RUN when run=1. RUN→HALT when run=0.
- HALT→STEP on step_req=1 (only if run=0).
- STEP→HALT once channel 0 completes one toggle, or →RUN if run=1 by then. In either case step_ack pulses.
- Any state→DONE when run_limit≠0 and cycles==run_limit. DONE is left only by ereset.
- Per-channel divider:
  - Counter cnt_i increments each active eclk.
  - At cnt_i==hp_i−1, clk0[i] toggles and cnt_i clears.
  - hp_i = max(half_period field,1), sampled at each toggle and at reset exit.
  - Period = 2*hp_i eclk.
- Per-channel reset:
  - Counter loads RESET_CYCLES on ereset or rst_req[i].
  - It decrements on each falling toggle of clk0[i].
  - res[i]=0 while counter≠0.
  - res[i] rises on the same eclk edge as the falling toggle that reaches 0.
- cycles increments on each falling toggle of clk0[0] and saturates at all-ones.
- Boundary rules:
  - rst_req[i] coincident with a falling toggle: reload wins (counter=RESET_CYCLES).
  - rst_req does not disturb clk0 or cnt_i, and works in any state, including HALT and DONE. Reset counters only decrement on toggles, so they make no progress while frozen.
  - step_req while in STEP, RUN or DONE: ignored, no ack.
  - Reaching the limit during STEP: go to DONE, no step_ack.
  - Changing run_limit below the current cycles value: no DONE until counter saturation equality.
  - Freezing (HALT/DONE) holds clk0, cnt_i and res levels exactly.

## Timing
- ereset=0 at a posedge gives the following on the next cycle: clk0=0, res=0, cnt=0, cycles=0, done=0, step_ack=0, state=HALT.
- With run=1 held from reset exit, first clk0[i] rise occurs hp_i eclk cycles after the first active cycle.
- done asserts on the same edge that cycles becomes run_limit. Dividers are frozen from the next eclk.
- step_ack asserts the eclk after channel 0 toggles, for exactly 1 cycle.
- All outputs are registered; no combinational input→output paths.

## Configuration
- CLKSEQ_STEP_EN defined:
  - STEP state and step_req/step_ack are implemented as above.
- Undefined:
  - STEP logic is removed.
  - step_req is ignored.
  - step_ack is tied 0.
  - The state machine has HALT/RUN/DONE only.

## Test plan
- NCHAN=2, half_period={4,1}, run=1 after reset -> clk0[0] period 8 eclk and clk0[1] period 2 eclk; res[0] rises on 8th clk0[0] fall (64 eclk after start); res[1] rises at 16 eclk.
- run_limit=5, half_period[0]=2 -> cycles counts to 5; done=1 on 5th fall (20 eclk); clk0 stays 0 thereafter despite run=1.
- Run 3 cycles, pulse rst_req[1] coincident with a clk0[1] fall -> res[1] low the next eclk, then RESET_CYCLES further falls before it rises; res[0] unaffected.
- run=0, CLKSEQ_STEP_EN, half_period[0]=3, step_req pulse -> exactly one clk0[0] toggle 3 eclk later; step_ack 1 cycle after it; second step_req during STEP yields no extra ack.
- half_period[0] changed 2→5 mid-half-period -> current half keeps 2, following halves are 5.
- ereset=0 asserted mid-run with done=1 -> all outputs back to reset values next eclk; a fresh run proceeds from cycles=0.
